ps2_keyboard: RTL and testbench

- Input-side counterpart to the game's VGA output path. Receives PS/2 device-to-host frames from the keyboard and decodes set-2 make/break codes.
- Drives the player/FSM control inputs: ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting, plus enter and bomb press pulses.
- Sits between the board PS/2 pins and the top-level game logic. Runs entirely in the system clock domain.

---
 rtl/ps2_pkg.sv | 49 ++++
 rtl/ps2_keyboard_if.sv | 18 +
 rtl/ps2_rx_frame.sv | 136 +++++++++++++
 rtl/ps2_keyboard.sv | 94 +++++++++
 tb/tb_ps2_keyboard.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, frame states and the key map for the PS/2 keyboard path.
package ps2_pkg;

  // Set-2 scan codes the game cares about
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BOMB  = 8'h22;
  localparam logic [7:0] SC_SHOOT = 8'h1A;

  // Bit positions of each key inside the held-key vector
  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_SHOOT  = 4;
  localparam int K_ENTER  = 5;
  localparam int K_BOMB   = 6;
  localparam int NUM_KEYS = 7;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  // One-hot mask of the key addressed by (ext, code); arrows only exist with the E0 prefix,
  // so the keypad codes without it fall through to zero.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
    key_mask = '0;
    if (ext) begin
      case (code)
        SC_UP:    key_mask[K_UP]    = 1'b1;
        SC_DOWN:  key_mask[K_DOWN]  = 1'b1;
        SC_LEFT:  key_mask[K_LEFT]  = 1'b1;
        SC_RIGHT: key_mask[K_RIGHT] = 1'b1;
        default:  key_mask = '0;
      endcase
    end else begin
      case (code)
        SC_SHOOT: key_mask[K_SHOOT] = 1'b1;
        SC_ENTER: key_mask[K_ENTER] = 1'b1;
        SC_BOMB:  key_mask[K_BOMB]  = 1'b1;
        default:  key_mask = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// Control and scan-code outputs from the keyboard decoder towards the game logic.
interface ps2_keyboard_if;
  logic       ctrl_up;
  logic       ctrl_down;
  logic       ctrl_left;
  logic       ctrl_right;
  logic       shooting;
  logic       enter;
  logic       bomb;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (output ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting,
                         enter, bomb, scan_code, scan_valid, frame_err);
  modport slave  (input  ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting,
                         enter, bomb, scan_code, scan_valid, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host byte receiver: synchronisers, clock glitch filter, 11-bit frame FSM
// with odd-parity check and a mid-frame inactivity timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int             FW       = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0]  FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [17:0]    TO_MAX   = 18'(TIMEOUT_CYCLES);

  logic          clk_meta, clk_sync, dat_meta, dat_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  frame_state_t  state_q, state_d;
  logic [7:0]    shift_q;
  logic [3:0]    bit_cnt;
  logic          parity_q;
  logic [17:0]   to_cnt;
  logic          byte_good, byte_bad;

  // Two-flop synchronisers; idle PS/2 lines are high so they reset to 1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      dat_meta <= ps2_data;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_MAX) begin
      filt_clk <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign strobe = filt_clk & ~clk_sync & (filt_cnt == FILT_MAX);

  // Frame state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next frame state plus good/bad byte decisions; timeout takes priority over any strobe
  always_comb begin
    state_d   = state_q;
    byte_good = 1'b0;
    byte_bad  = 1'b0;
    if (state_q != IDLE && to_cnt == TO_MAX) begin
      state_d  = IDLE;
      byte_bad = 1'b1;
    end else if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (dat_sync) byte_bad = 1'b1;
          else          state_d  = DATA;
        end
        DATA: begin
          if (bit_cnt == 4'd7) state_d = PARITY;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (dat_sync && (^{shift_q, parity_q})) byte_good = 1'b1;
          else                                    byte_bad  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register, bit counter, parity capture and saturating inactivity counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      to_cnt   <= '0;
    end else begin
      if (strobe || state_q == IDLE) to_cnt <= '0;
      else if (to_cnt != TO_MAX)     to_cnt <= to_cnt + 18'd1;
      if (strobe) begin
        case (state_q)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift_q <= {dat_sync, shift_q[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          PARITY:  parity_q <= dat_sync;
          default: parity_q <= parity_q;
        endcase
      end
    end
  end

  // Registered byte/valid/error results, one clk after the deciding strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= byte_good;
      rx_err   <= byte_bad;
      if (byte_good) rx_byte <= shift_q;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receives set-2 bytes and turns make/break codes into held
// control levels and fresh-press pulses for the game.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic rstn,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_keyboard_if.master kb
);

  logic [7:0]          rx_byte;
  logic                rx_valid, rx_err;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [NUM_KEYS-1:0] held_q, held_d, hit;
  logic                enter_q, enter_d, bomb_q, bomb_d;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rstn    (rstn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  // Decode one byte: prefixes set flags, other codes update the held map and clear the flags
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    held_d  = held_q;
    enter_d = 1'b0;
    bomb_d  = 1'b0;
    hit     = '0;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        hit = key_mask(ext_q, rx_byte);
        if (brk_q) begin
          held_d = held_q & ~hit;
        end else begin
          held_d  = held_q | hit;
          enter_d = hit[K_ENTER] & ~held_q[K_ENTER];
          bomb_d  = hit[K_BOMB] & ~held_q[K_BOMB];
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Decoder flags, held keys and press pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= '0;
      enter_q <= 1'b0;
      bomb_q  <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      held_q  <= held_d;
      enter_q <= enter_d;
      bomb_q  <= bomb_d;
    end
  end

  assign kb.ctrl_up    = held_q[K_UP];
  assign kb.ctrl_down  = held_q[K_DOWN];
  assign kb.ctrl_left  = held_q[K_LEFT];
  assign kb.ctrl_right = held_q[K_RIGHT];
  assign kb.shooting   = held_q[K_SHOOT];
  assign kb.enter      = enter_q;
  assign kb.bomb       = bomb_q;
  assign kb.scan_code  = rx_byte;
  assign kb.scan_valid = rx_valid;
  assign kb.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed key scenarios plus random byte streams,
// compared against an event-level keyboard model.
module tb_ps2_keyboard;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HB             = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_if kb();

  ps2_keyboard #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kb      (kb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // model: bit 0 up, 1 down, 2 left, 3 right, 4 shoot, 5 enter, 6 bomb
  bit         m_ext, m_brk;
  bit   [6:0] m_held;
  bit         exp_enter, exp_bomb;
  logic [8:0] exp_q[$];
  logic [8:0] mon_ev;
  int         enter_seen = 0;
  int         bomb_seen = 0;
  int         stray = 0;
  bit         pending = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h6B) return 2;
      if (b == 8'h74) return 3;
    end else begin
      if (b == 8'h1A) return 4;
      if (b == 8'h5A) return 5;
      if (b == 8'h22) return 6;
    end
    return -1;
  endfunction

  task automatic model_apply(input logic [8:0] ev);
    int k;
    exp_enter = 1'b0;
    exp_bomb  = 1'b0;
    if (ev[8]) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (ev[7:0] == 8'hE0) begin
      m_ext = 1'b1;
    end else if (ev[7:0] == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      k = key_of(m_ext, ev[7:0]);
      if (k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else begin
          if (k == 5 && !m_held[5]) exp_enter = 1'b1;
          if (k == 6 && !m_held[6]) exp_bomb = 1'b1;
          m_held[k] = 1'b1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_held = '0;
    exp_enter = 1'b0;
    exp_bomb = 1'b0;
  endtask

  // Event monitor: pops expected events on scan_valid/frame_err and checks decoder outputs a cycle later
  always @(negedge clk) begin
    if (!rstn) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        checkOutput("keys", 32'({kb.ctrl_up, kb.ctrl_down, kb.ctrl_left, kb.ctrl_right, kb.shooting}),
                    32'({m_held[0], m_held[1], m_held[2], m_held[3], m_held[4]}));
        checkOutput("enter_pulse", 32'(kb.enter), 32'(exp_enter));
        checkOutput("bomb_pulse", 32'(kb.bomb), 32'(exp_bomb));
        pending = 1'b0;
      end else if (kb.enter || kb.bomb) begin
        stray++;
      end
      if (kb.enter) enter_seen++;
      if (kb.bomb) bomb_seen++;
      if (kb.scan_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_valid", 32'(kb.scan_valid), 32'd0);
        else begin
          mon_ev = exp_q.pop_front();
          checkOutput("scan_valid_event", 32'({1'b0, kb.scan_code}), 32'(mon_ev));
          model_apply(mon_ev);
          pending = 1'b1;
        end
      end
      if (kb.frame_err) begin
        if (exp_q.size() == 0) checkOutput("unexpected_err", 32'(kb.frame_err), 32'd0);
        else begin
          mon_ev = exp_q.pop_front();
          checkOutput("frame_err_event", 32'(kb.frame_err), 32'(mon_ev[8]));
          model_apply(mon_ev);
          pending = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HB / 2);
      ps2_clk = 1'b0;
      tick(HB);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        tick(HB / 2);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
      end
      tick(HB / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain_check();
    tick(HB * 2);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
    exp_q.push_back({bad_par | bad_stop, b});
    send_bits(frame_bits(b, bad_par, bad_stop), 11, glitch_at);
    drain_check();
  endtask

  task automatic send_good(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b0, -1);
  endtask

  task automatic bad_start();
    exp_q.push_back(9'h100);
    send_bits(11'h001, 1, -1);
    drain_check();
  endtask

  logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h22, 8'h1A, 8'hAA, 8'hE1, 8'hFA};

  initial begin
    int s;
    int r;
    logic [7:0] b;
    model_reset();
    tick(3);
    checkOutput("reset_outputs", 32'({kb.ctrl_up, kb.ctrl_down, kb.ctrl_left, kb.ctrl_right, kb.shooting,
                kb.enter, kb.bomb, kb.scan_code, kb.scan_valid, kb.frame_err}), 32'd0);
    rstn = 1'b1;
    tick(5);

    s = enter_seen;
    send_good(8'h5A);
    checkOutput("enter_once", 32'(enter_seen - s), 32'd1);
    checkOutput("last_code", 32'(kb.scan_code), 32'h5A);

    send_good(8'hE0);
    checkOutput("up_after_e0", 32'(kb.ctrl_up), 32'd0);
    send_good(8'h75);
    checkOutput("up_make", 32'(kb.ctrl_up), 32'd1);
    send_good(8'hE0);
    send_good(8'hF0);
    checkOutput("up_before_break", 32'(kb.ctrl_up), 32'd1);
    send_good(8'h75);
    checkOutput("up_break", 32'(kb.ctrl_up), 32'd0);
    send_good(8'h75);
    checkOutput("keypad_8_no_up", 32'(kb.ctrl_up), 32'd0);

    s = bomb_seen;
    repeat (3) send_good(8'h22);
    send_good(8'hF0);
    send_good(8'h22);
    send_good(8'h22);
    checkOutput("bomb_count", 32'(bomb_seen - s), 32'd2);
    repeat (3) send_good(8'h1A);
    checkOutput("shoot_held", 32'(kb.shooting), 32'd1);
    send_good(8'hF0);
    send_good(8'h1A);
    checkOutput("shoot_released", 32'(kb.shooting), 32'd0);

    applyStimulus(8'h1A, 1'b1, 1'b0, -1);
    checkOutput("shoot_after_parity_err", 32'(kb.shooting), 32'd0);
    send_good(8'h1A);
    checkOutput("shoot_after_good", 32'(kb.shooting), 32'd1);

    send_good(8'hE0);
    exp_q.push_back(9'h100);
    send_bits(frame_bits(8'h6B, 1'b0, 1'b0), 5, -1);
    tick(TIMEOUT_CYCLES + 10);
    drain_check();
    send_good(8'h6B);
    checkOutput("left_ext_cleared", 32'(kb.ctrl_left), 32'd0);
    send_good(8'hE0);
    send_good(8'h6B);
    checkOutput("left_after_timeout", 32'(kb.ctrl_left), 32'd1);

    send_good(8'hE0);
    applyStimulus(8'h74, 1'b0, 1'b0, 3);
    checkOutput("right_with_glitch", 32'(kb.ctrl_right), 32'd1);
    bad_start();
    applyStimulus(8'h22, 1'b0, 1'b1, -1);

    send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5, -1);
    rstn = 1'b0;
    tick(2);
    checkOutput("midframe_reset", 32'({kb.ctrl_up, kb.ctrl_down, kb.ctrl_left, kb.ctrl_right, kb.shooting,
                kb.enter, kb.bomb, kb.scan_code, kb.scan_valid, kb.frame_err}), 32'd0);
    exp_q.delete();
    model_reset();
    rstn = 1'b1;
    tick(HB);
    send_good(8'h1A);
    checkOutput("decode_after_reset", 32'(kb.shooting), 32'd1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      if (r < 5)       applyStimulus(b, 1'b1, 1'b0, -1);
      else if (r < 9)  applyStimulus(b, 1'b0, 1'b1, -1);
      else if (r < 12) bad_start();
      else             send_good(b);
    end

    checkOutput("stray_pulses", 32'(stray), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
